// File: rtl/apb_pkg.sv
// Shared APB4 definitions: FSM state encoding, wait-counter width and the
// strobe-width helper used to size PSTRB from the data width.
package apb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   // Wide enough for WAIT_STATES in 0..7.
   localparam int unsigned WAIT_W = 3;

   localparam int unsigned BYTE_W = 8;

   // Number of byte lanes (PSTRB bits) for a given data width.
   function automatic int unsigned strb_width(input int unsigned data_width);
      return data_width / BYTE_W;
   endfunction

endpackage

// File: rtl/apb4_regbank_if.sv
// APB4 completer-side bus bundle.
// Ports (master drives): PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB.
// Ports (slave drives):  PRDATA, PREADY, PSLVERR.
interface apb4_regbank_if
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0]             PADDR;
   logic                              PSEL;
   logic                              PENABLE;
   logic                              PWRITE;
   logic [DATA_WIDTH-1:0]             PWDATA;
   logic [strb_width(DATA_WIDTH)-1:0] PSTRB;
   logic [DATA_WIDTH-1:0]             PRDATA;
   logic                              PREADY;
   logic                              PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb4_reg_storage.sv
// Register array for apb4_regbank: byte-strobed writes, read-only registers
// tied to their reset value, and the read mux.
// Ports: clk/rst (async active-high), wr_en/wr_idx/wr_data/wr_strb write
// port, rd_idx -> rd_data read port, regs = flattened live contents.
module apb4_reg_storage
   import apb_pkg::*;
#(
   parameter int unsigned                     DATA_WIDTH = 32,
   parameter int unsigned                     NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0]             RO_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL  = '0,
   localparam int unsigned                    STRB_W     = strb_width(DATA_WIDTH),
   localparam int unsigned                    IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic [IDX_W-1:0]               wr_idx,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   input  logic [STRB_W-1:0]              wr_strb,
   input  logic [IDX_W-1:0]               rd_idx,
   output logic [DATA_WIDTH-1:0]          rd_data,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (RO_MASK[i]) begin : g_ro
         // Read-only registers have no storage; they always show their reset value.
         assign regs[i*DATA_WIDTH +: DATA_WIDTH] = RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_rw
         logic [DATA_WIDTH-1:0] reg_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               reg_q <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (wr_en && (wr_idx == IDX_W'(i))) begin
               for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (wr_strb[b]) begin
                     reg_q[b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
                  end
               end
            end
         end

         assign regs[i*DATA_WIDTH +: DATA_WIDTH] = reg_q;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_data = regs[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/apb4_regbank.sv
// APB4 register bank: IDLE/ACCESS FSM, programmable wait states, error
// decode (out-of-range index or write to a read-only register).
// Ports: PCLK, PRESET (async active-high), bus (APB4 slave modport),
// regs_o = flattened live register contents, register i in slice i.
module apb4_regbank
   import apb_pkg::*;
#(
   parameter int unsigned                     ADDR_WIDTH  = 8,
   parameter int unsigned                     DATA_WIDTH  = 32,
   parameter int unsigned                     NUM_REGS    = 16,
   parameter int unsigned                     WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]             RO_MASK     = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL   = '0
) (
   input  logic                           PCLK,
   input  logic                           PRESET,
   apb4_regbank_if.slave                  bus,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

   localparam int unsigned OFF_W = $clog2(strb_width(DATA_WIDTH));
   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   apb_state_e          state_q, state_d;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [IDX_W-1:0]    idx;
   logic                valid, err, ready, complete, wr_en;
   logic [DATA_WIDTH-1:0] rd_data;

   assign word_addr = bus.PADDR >> OFF_W;
   assign idx       = word_addr[IDX_W-1:0];
   assign valid     = 32'(word_addr) < NUM_REGS;
   assign err       = !valid || (bus.PWRITE && RO_MASK[idx]);

   // Idle-ready: PREADY is high outside ACCESS.
   assign ready     = (state_q == IDLE) || (cnt_q == '0);
   assign complete  = (state_q == ACCESS) && (cnt_q == '0) && bus.PSEL && bus.PENABLE;
   assign wr_en     = complete && bus.PWRITE && !err;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.PSEL && !bus.PENABLE) begin
               state_d = ACCESS;
               cnt_d   = WAIT_W'(WAIT_STATES);
            end
         end
         ACCESS: begin
            if (!bus.PSEL || complete) begin
               // Abort or completion; an abort never reaches the write port.
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   apb4_reg_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .RO_MASK    (RO_MASK),
      .RESET_VAL  (RESET_VAL)
   ) u_storage (
      .clk     (PCLK),
      .rst     (PRESET),
      .wr_en   (wr_en),
      .wr_idx  (idx),
      .wr_data (bus.PWDATA),
      .wr_strb (bus.PSTRB),
      .rd_idx  (idx),
      .rd_data (rd_data),
      .regs    (regs_o)
   );

   assign bus.PREADY  = ready;
   assign bus.PSLVERR = complete && err;
   assign bus.PRDATA  = ((state_q == ACCESS) && (cnt_q == '0) && !bus.PWRITE && valid)
                        ? rd_data : '0;

endmodule

// File: tb/tb_apb4_regbank.sv
// Directed bench for apb4_regbank. Three instances share one bus driver:
// u_dut0 (no wait states, reg 0 read-only), u_dut1 (3 wait states) and
// u_dut2 (2 wait states, used for the mid-transfer reset case).
module tb_apb4_regbank;
   import apb_pkg::*;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 16;
   localparam int unsigned RW = NR * DW;

   localparam logic [RW-1:0] RV0 = (RW'(32'h1122_3344) << 64) | RW'(32'hC0DE_0000);
   localparam logic [RW-1:0] RV1 = RW'(32'h5A5A_5A5A);
   localparam logic [RW-1:0] RV2 = RW'(32'h0000_0101) << 32;

   logic PCLK = 1'b0;
   logic PRESET = 1'b0;
   always #5 PCLK = ~PCLK;

   logic [AW-1:0] paddr = '0;
   logic          psel = 1'b0;
   logic          penable = 1'b0;
   logic          pwrite = 1'b0;
   logic [DW-1:0] pwdata = '0;
   logic [3:0]    pstrb = '0;
   int            tgt = 0;

   logic [DW-1:0] prdata;
   logic          pready, pslverr;
   logic [RW-1:0] regs0, regs1, regs2;

   apb4_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
   apb4_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
   apb4_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

   assign if0.PADDR = paddr;  assign if1.PADDR = paddr;  assign if2.PADDR = paddr;
   assign if0.PENABLE = penable; assign if1.PENABLE = penable; assign if2.PENABLE = penable;
   assign if0.PWRITE = pwrite; assign if1.PWRITE = pwrite; assign if2.PWRITE = pwrite;
   assign if0.PWDATA = pwdata; assign if1.PWDATA = pwdata; assign if2.PWDATA = pwdata;
   assign if0.PSTRB = pstrb;  assign if1.PSTRB = pstrb;  assign if2.PSTRB = pstrb;
   assign if0.PSEL = psel && (tgt == 0);
   assign if1.PSEL = psel && (tgt == 1);
   assign if2.PSEL = psel && (tgt == 2);

   always_comb begin
      prdata  = if0.PRDATA;
      pready  = if0.PREADY;
      pslverr = if0.PSLVERR;
      case (tgt)
         1: begin prdata = if1.PRDATA; pready = if1.PREADY; pslverr = if1.PSLVERR; end
         2: begin prdata = if2.PRDATA; pready = if2.PREADY; pslverr = if2.PSLVERR; end
         default: ;
      endcase
   end

   apb4_regbank #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_REGS (NR), .WAIT_STATES (0),
      .RO_MASK (16'h0001), .RESET_VAL (RV0)
   ) u_dut0 (.PCLK (PCLK), .PRESET (PRESET), .bus (if0), .regs_o (regs0));

   apb4_regbank #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_REGS (NR), .WAIT_STATES (3),
      .RO_MASK (16'h0000), .RESET_VAL (RV1)
   ) u_dut1 (.PCLK (PCLK), .PRESET (PRESET), .bus (if1), .regs_o (regs1));

   apb4_regbank #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_REGS (NR), .WAIT_STATES (2),
      .RO_MASK (16'h0000), .RESET_VAL (RV2)
   ) u_dut2 (.PCLK (PCLK), .PRESET (PRESET), .bus (if2), .regs_o (regs2));

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts at PCLK posedge + 1 and returns at posedge + 1 after the completing
   // edge with the bus released, so a following call is a back-to-back setup.
   task automatic xfer(input int t, input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] d, input logic [3:0] s,
                       output logic [DW-1:0] rd, output logic er,
                       output int waits, output logic early);
      tgt = t; paddr = a; pwrite = w; pwdata = d; pstrb = s;
      psel = 1'b1; penable = 1'b0;
      @(posedge PCLK); #1;
      penable = 1'b1;
      waits = 0;
      early = 1'b0;
      @(negedge PCLK);
      while (!pready && waits < 16) begin
         waits++;
         if (prdata !== '0) early = 1'b1;
         @(negedge PCLK);
      end
      rd = prdata;
      er = pslverr;
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   logic [DW-1:0] rd;
   logic          er, early;
   int            wt;
   logic [RW-1:0] exp0;

   initial begin
      exp0 = RV0;
      #2 PRESET = 1'b1;
      #1;
      check("rst_pready", RW'(pready), RW'(1'b1));
      check("rst_prdata", RW'(prdata), '0);
      check("rst_pslverr", RW'(pslverr), '0);
      check("rst_regs0", regs0, RV0);
      check("rst_regs1", regs1, RV1);
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1'b0;

      // Zero-wait write then read.
      xfer(0, 8'h04, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, wt, early);
      check("wr04_waits", RW'(wt), '0);
      check("wr04_err", RW'(er), '0);
      exp0[32 +: 32] = 32'hDEAD_BEEF;
      check("wr04_regs", regs0, exp0);
      xfer(0, 8'h04, 1'b0, '0, 4'h0, rd, er, wt, early);
      check("rd04_data", RW'(rd), RW'(32'hDEAD_BEEF));
      check("rd04_err", RW'(er), '0);
      xfer(0, 8'h07, 1'b0, '0, 4'h0, rd, er, wt, early);
      check("rd07_offset_ignored", RW'(rd), RW'(32'hDEAD_BEEF));

      // Byte strobes on reg 2.
      xfer(0, 8'h08, 1'b1, 32'hAABB_CCDD, 4'h5, rd, er, wt, early);
      exp0[64 +: 32] = 32'h11BB_33DD;
      check("strb5_regs", regs0, exp0);
      xfer(0, 8'h08, 1'b0, '0, 4'h0, rd, er, wt, early);
      check("strb5_read", RW'(rd), RW'(32'h11BB_33DD));

      // PSTRB=0 is a no-op without error.
      xfer(0, 8'h0C, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, er, wt, early);
      check("strb0_err", RW'(er), '0);
      check("strb0_regs", regs0, exp0);

      // Out-of-range write and read.
      xfer(0, 8'h40, 1'b1, 32'h1234_5678, 4'hF, rd, er, wt, early);
      check("oor_wr_err", RW'(er), RW'(1'b1));
      check("oor_wr_regs", regs0, exp0);
      check("err_one_cycle", RW'(pslverr), '0);
      xfer(0, 8'h40, 1'b0, '0, 4'h0, rd, er, wt, early);
      check("oor_rd_err", RW'(er), RW'(1'b1));
      check("oor_rd_data", RW'(rd), '0);

      // Write to read-only reg 0.
      xfer(0, 8'h00, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, wt, early);
      check("ro_wr_err", RW'(er), RW'(1'b1));
      check("ro_wr_regs", regs0, exp0);
      xfer(0, 8'h00, 1'b0, '0, 4'h0, rd, er, wt, early);
      check("ro_rd_data", RW'(rd), RW'(32'hC0DE_0000));
      check("ro_rd_err", RW'(er), '0);

      // Back-to-back writes, no idle cycle between them.
      xfer(0, 8'h08, 1'b1, 32'h0102_0304, 4'hF, rd, er, wt, early);
      check("b2b_first_waits", RW'(wt), '0);
      xfer(0, 8'h0C, 1'b1, 32'h0A0B_0C0D, 4'hF, rd, er, wt, early);
      check("b2b_second_waits", RW'(wt), '0);
      exp0[64 +: 32] = 32'h0102_0304;
      exp0[96 +: 32] = 32'h0A0B_0C0D;
      check("b2b_regs", regs0, exp0);

      // Three wait states.
      xfer(1, 8'h00, 1'b0, '0, 4'h0, rd, er, wt, early);
      check("ws3_waits", RW'(wt), RW'(3));
      check("ws3_early_prdata", RW'(early), '0);
      check("ws3_data", RW'(rd), RW'(32'h5A5A_5A5A));
      check("ws3_err", RW'(er), '0);
      check("ws3_idle_prdata", RW'(prdata), '0);

      // Reset in the middle of a 2-wait-state write.
      tgt = 2; paddr = 8'h04; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
      psel = 1'b1; penable = 1'b0;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(negedge PCLK);
      check("mid_pready_low", RW'(pready), '0);
      PRESET = 1'b1;
      #1;
      check("mid_rst_pready", RW'(pready), RW'(1'b1));
      check("mid_rst_pslverr", RW'(pslverr), '0);
      check("mid_rst_reg1", RW'(regs2[32 +: 32]), RW'(32'h0000_0101));
      psel = 1'b0; penable = 1'b0;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      check("post_rst_reg1", RW'(regs2[32 +: 32]), RW'(32'h0000_0101));
      xfer(2, 8'h04, 1'b1, 32'h1357_2468, 4'hF, rd, er, wt, early);
      check("post_rst_waits", RW'(wt), RW'(2));
      check("post_rst_err", RW'(er), '0);
      check("post_rst_commit", RW'(regs2[32 +: 32]), RW'(32'h1357_2468));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
